// File: rtl/turbo_param_table_loader_if.sv
// Host-stream and decoder-read signal bundle for the turbo interleaver parameter table loader.
// The master side is the host/decoder; the slave side is the loader itself.
interface turbo_param_table_loader_if #(
    parameter int RAM_WIDTH     = 24,
    parameter int RAM_ADDR_BITS = 10
);
    logic                     load_start;
    logic [RAM_WIDTH-1:0]     wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [RAM_ADDR_BITS-1:0] read_address;
    logic [RAM_WIDTH-1:0]     output_data;
    logic                     table_valid;
    logic                     load_busy;
    logic                     load_abort;
    logic [RAM_ADDR_BITS:0]   wr_count;
    logic [RAM_WIDTH-1:0]     checksum;

    modport master (
        output load_start, wr_data, wr_valid, read_address,
        input  wr_ready, output_data, table_valid, load_busy, load_abort, wr_count, checksum
    );

    modport slave (
        input  load_start, wr_data, wr_valid, read_address,
        output wr_ready, output_data, table_valid, load_busy, load_abort, wr_count, checksum
    );
endinterface

// File: rtl/turbo_param_table_loader.sv
// Run-time reloadable turbo interleaver parameter table: host stream writes the RAM,
// decoder reads it through a registered read-first port.
//
//  state  | meaning
//  IDLE   | no table loaded since reset
//  LOAD   | accepting words into entries 0..TABLE_DEPTH-1
//  DONE   | complete table present, table_valid high
module turbo_param_table_loader #(
    parameter int RAM_WIDTH     = 24,
    parameter int RAM_ADDR_BITS = 10,
    parameter int TABLE_DEPTH   = 565
) (
    input  logic                        clk,
    input  logic                        rst,
    turbo_param_table_loader_if.slave   bus
);
    localparam int CW        = RAM_ADDR_BITS + 1;
    localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;
    localparam logic [CW-1:0] LAST_IDX = CW'(TABLE_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_W  = CW'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [CW-1:0]        wr_count;
    logic [RAM_WIDTH-1:0] checksum;
    logic [RAM_WIDTH-1:0] output_data;
    logic                 table_valid;
    logic                 load_abort;
    logic                 wr_ready;
    logic                 accept;
    logic                 last_beat;
    logic                 addr_in_range;

    always_comb begin
        state_next = state;
        wr_ready   = (state == S_LOAD) && !bus.load_start;
        accept     = bus.wr_valid && wr_ready;
        last_beat  = accept && (wr_count == LAST_IDX);
        case (state)
            S_IDLE:  if (bus.load_start) state_next = S_LOAD;
            S_LOAD:  begin
                if (bus.load_start)  state_next = S_LOAD;
                else if (last_beat)  state_next = S_DONE;
            end
            S_DONE:  if (bus.load_start) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count    <= '0;
            checksum    <= '0;
            table_valid <= 1'b0;
            load_abort  <= 1'b0;
        end else begin
            load_abort <= (state == S_LOAD) && bus.load_start;
            if (bus.load_start) begin
                wr_count    <= '0;
                checksum    <= '0;
                table_valid <= 1'b0;
            end else if (accept) begin
                wr_count <= wr_count + 1'b1;
                checksum <= checksum ^ bus.wr_data;
                if (last_beat) table_valid <= 1'b1;
            end
        end
    end

    // RAM is deliberately left out of reset; a reset mid-load only drops the table logically.
    always_ff @(posedge clk) begin
        if (accept && !rst) ram[wr_count[RAM_ADDR_BITS-1:0]] <= bus.wr_data;
    end

    assign addr_in_range = ({1'b0, bus.read_address} < DEPTH_W);

    // Same-edge write and read of one address returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst)                output_data <= '0;
        else if (addr_in_range) output_data <= ram[bus.read_address];
        else                    output_data <= '0;
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.output_data = output_data;
    assign bus.table_valid = table_valid;
    assign bus.load_busy   = (state == S_LOAD);
    assign bus.load_abort  = load_abort;
    assign bus.wr_count    = wr_count;
    assign bus.checksum    = checksum;
endmodule

// File: tb/tb_turbo_param_table_loader.sv
// Self-checking bench for turbo_param_table_loader: a table-level reference model is
// compared against the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_turbo_param_table_loader;
    localparam int W     = 24;
    localparam int AB    = 10;
    localparam int DEPTH = 565;

    logic clk;
    logic rst;

    turbo_param_table_loader_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    turbo_param_table_loader #(
        .RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .TABLE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int abort_seen = 0;

    // Reference model: the table contents plus what the host has delivered so far.
    logic [W-1:0] mem   [1 << AB];
    bit           known [1 << AB];
    bit           m_loading, m_valid, m_abort, m_out_known;
    int           m_count;
    logic [W-1:0] m_xor, m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic         rs, li, wv;
        logic [W-1:0] wd;
        int           ra;
        for (int i = 0; i < (1 << AB); i++) known[i] = 1'b0;
        m_loading = 0; m_valid = 0; m_abort = 0; m_count = 0; m_xor = '0;
        m_out = '0; m_out_known = 0;
        forever begin
            @(posedge clk);
            rs = rst; li = bus.load_start; wv = bus.wr_valid; wd = bus.wr_data;
            ra = int'(bus.read_address);
            if (rs) begin
                m_loading = 0; m_valid = 0; m_abort = 0; m_count = 0; m_xor = '0;
                m_out = '0; m_out_known = 1;
            end else begin
                if (ra >= DEPTH) begin
                    m_out = '0; m_out_known = 1;
                end else begin
                    m_out = mem[ra]; m_out_known = known[ra];
                end
                m_abort = m_loading && li;
                if (li) begin
                    m_loading = 1; m_valid = 0; m_count = 0; m_xor = '0;
                end else if (m_loading && wv) begin
                    mem[m_count] = wd;
                    known[m_count] = 1'b1;
                    m_count++;
                    m_xor ^= wd;
                    if (m_count == DEPTH) begin
                        m_loading = 0; m_valid = 1;
                    end
                end
            end
            #1;
            if (bus.load_abort) abort_seen++;
            chk("table_valid", 32'(bus.table_valid), 32'(m_valid));
            chk("load_busy",   32'(bus.load_busy),   32'(m_loading));
            chk("load_abort",  32'(bus.load_abort),  32'(m_abort));
            chk("wr_count",    32'(bus.wr_count),    32'(m_count));
            chk("checksum",    32'(bus.checksum),    32'(m_xor));
            chk("wr_ready",    32'(bus.wr_ready),    32'(m_loading && !bus.load_start));
            if (m_out_known) chk("output_data", 32'(bus.output_data), 32'(m_out));
        end
    end

    task automatic start_load();
        bus.load_start = 1'b1;
        bus.wr_valid   = 1'b0;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    // dmode: 0 = k*3, 1 = 0x000AAA, 2 = random. vmode: 0 = back-to-back, 1 = every other, 2 = random stalls.
    task automatic stream(input int n, input int dmode, input int vmode,
                          input int probe_k, input logic [W-1:0] probe_old);
        int   k  = 0;
        int   cn = 0;
        logic acc;
        while (k < n && cn < 8 * n + 50) begin
            case (vmode)
                0:       bus.wr_valid = 1'b1;
                1:       bus.wr_valid = (cn % 2 == 0);
                default: bus.wr_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (dmode)
                0:       bus.wr_data = W'(k * 3);
                1:       bus.wr_data = 24'h000AAA;
                default: bus.wr_data = W'($urandom);
            endcase
            bus.read_address = (k == probe_k) ? AB'(probe_k) : AB'($urandom_range(0, 1023));
            #1 acc = bus.wr_valid && bus.wr_ready;
            @(negedge clk);
            if (acc && k == probe_k) chk("same_edge_read", 32'(bus.output_data), 32'(probe_old));
            if (acc) k++;
            cn++;
        end
        bus.wr_valid = 1'b0;
        chk("stream_accepted_beats", 32'(k), 32'(n));
    endtask

    task automatic read_lit(input int addr, input logic [W-1:0] exp, input string name);
        bus.read_address = AB'(addr);
        @(negedge clk);
        chk(name, 32'(bus.output_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.load_start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0; bus.read_address = '0;
        repeat (2) @(negedge clk);
        chk("reset_table_valid", 32'(bus.table_valid), 32'd0);
        chk("reset_wr_count",    32'(bus.wr_count),    32'd0);
        chk("reset_output_data", 32'(bus.output_data), 32'd0);
        rst = 1'b0;

        // Writes in IDLE are ignored.
        bus.wr_valid = 1'b1; bus.wr_data = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        chk("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("idle_wr_count", 32'(bus.wr_count), 32'd0);
        chk("idle_checksum", 32'(bus.checksum), 32'd0);
        bus.wr_valid = 1'b0;

        // Full back-to-back load of k*3.
        start_load();
        stream(DEPTH, 0, 0, -1, '0);
        chk("s1_table_valid", 32'(bus.table_valid), 32'd1);
        chk("s1_wr_count",    32'(bus.wr_count),    32'd565);
        chk("s1_wr_ready",    32'(bus.wr_ready),    32'd0);
        read_lit(0,   24'd0,    "s1_read_0");
        read_lit(1,   24'd3,    "s1_read_1");
        read_lit(564, 24'd1692, "s1_read_564");
        read_lit(600, 24'd0,    "s6_read_600");

        // Writes in DONE are ignored.
        bus.wr_valid = 1'b1; bus.wr_data = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        chk("done_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("done_wr_count", 32'(bus.wr_count), 32'd565);
        bus.wr_valid = 1'b0;
        read_lit(2, 24'd6, "done_read_2");

        // Same load with gaps.
        start_load();
        stream(DEPTH, 0, 1, -1, '0);
        chk("s2_table_valid", 32'(bus.table_valid), 32'd1);
        read_lit(564, 24'd1692, "s2_read_564");

        // Partial load, restart (with a beat offered alongside load_start), then constant load.
        abort_seen = 0;
        start_load();
        stream(100, 2, 0, -1, '0);
        bus.load_start = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 24'hFFFFFF;
        @(negedge clk);
        bus.load_start = 1'b0; bus.wr_valid = 1'b0;
        stream(DEPTH, 1, 0, -1, '0);
        @(negedge clk);
        chk("s3_abort_pulses", 32'(abort_seen),       32'd1);
        chk("s3_wr_count",     32'(bus.wr_count),     32'd565);
        chk("s3_checksum",     32'(bus.checksum),     32'h000AAA);
        chk("s3_table_valid",  32'(bus.table_valid),  32'd1);

        // Same-edge write/read of entry 5 returns the previous table's word.
        start_load();
        stream(DEPTH, 2, 0, 5, 24'h000AAA);
        read_lit(600, 24'd0, "s6_read_600_after_load");

        // Reset at beat 300.
        start_load();
        stream(300, 2, 0, -1, '0);
        bus.wr_valid = 1'b1; bus.wr_data = W'($urandom);
        rst = 1'b1;
        @(negedge clk);
        chk("s5_table_valid", 32'(bus.table_valid), 32'd0);
        chk("s5_load_busy",   32'(bus.load_busy),   32'd0);
        chk("s5_wr_count",    32'(bus.wr_count),    32'd0);
        chk("s5_output_data", 32'(bus.output_data), 32'd0);
        rst = 1'b0; bus.wr_valid = 1'b0;
        @(negedge clk);

        // Randomised partial loads, restarts and stalled full loads.
        for (int it = 0; it < 3; it++) begin
            start_load();
            stream($urandom_range(0, DEPTH - 1), 2, 2, -1, '0);
            start_load();
            stream(DEPTH, 2, 2, -1, '0);
            repeat (4) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
